// File: rtl/present_arbiter.sv
// present_arbiter: shares one PRESENT cipher core between two requesters.
// One block is outstanding at a time. Grants alternate round-robin when both
// requesters contend. A core that never signals end-of-computation is
// reported to the consumer as an error response instead of hanging the port.
module present_arbiter #(
  parameter int TIMEOUT = 40
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [63:0]  req0_plaintext,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [63:0]  req1_plaintext,
  input  logic [127:0] req1_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [63:0]  rsp_data,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic         core_start,
  output logic [63:0]  core_plaintext,
  output logic [127:0] core_key,
  input  logic         core_eoc,
  input  logic [63:0]  core_ciphertext
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic             any_valid;
  logic [CNT_W-1:0] count;

  // Round-robin pick: on contention the requester not served last time wins;
  // a lone requester always wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  end

  // Handshake readys are only offered in IDLE, only to the granted requester,
  // and are forced low while reset is asserted.
  always_comb begin
    req0_ready = nrst && (state == IDLE) && req0_valid && !grant;
    req1_ready = nrst && (state == IDLE) && req1_valid &&  grant;
  end

  // Control FSM with registered outputs. The counter is cleared on accept and
  // counts cycles since the start pulse, so it equals TIMEOUT in the last RUN
  // cycle; the response then appears TIMEOUT+1 cycles after START. An eoc in
  // that same last cycle still counts as success.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      count          <= '0;
      core_start     <= 1'b0;
      core_plaintext <= '0;
      core_key       <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_id         <= 1'b0;
      rsp_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          core_start <= 1'b0;
          if (any_valid) begin
            core_plaintext <= grant ? req1_plaintext : req0_plaintext;
            core_key       <= grant ? req1_key       : req0_key;
            rsp_id         <= grant;
            last_grant     <= grant;
            count          <= '0;
            core_start     <= 1'b1;
            state          <= START;
          end
        end
        START: begin
          core_start <= 1'b0;
          count      <= count + 1'b1;
          state      <= RUN;
        end
        RUN: begin
          if (core_eoc) begin
            rsp_data  <= core_ciphertext;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (count == CNT_MAX) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            count <= count + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_arbiter.sv
// Directed bench for present_arbiter with a stub cipher core whose eoc delay
// (counted from the start-pulse cycle) can be set or disabled per test.
module tb_present_arbiter;

  localparam int TIMEOUT = 40;

  logic         clk = 1'b0;
  logic         nrst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [63:0]  req0_plaintext, req1_plaintext;
  logic [127:0] req0_key, req1_key;
  logic         rsp_valid, rsp_ready;
  logic [63:0]  rsp_data;
  logic         rsp_id, rsp_err;
  logic         core_start;
  logic [63:0]  core_plaintext;
  logic [127:0] core_key;
  logic         core_eoc;
  logic [63:0]  core_ciphertext;

  int n_cmp = 0;
  int n_err = 0;

  present_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nrst(nrst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_plaintext(req0_plaintext), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_plaintext(req1_plaintext), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
    .core_start(core_start), .core_plaintext(core_plaintext), .core_key(core_key),
    .core_eoc(core_eoc), .core_ciphertext(core_ciphertext)
  );

  always #5 clk = ~clk;

  // Stub cipher: the all-zero vector gives the real PRESENT-128 result,
  // other operands give an arbitrary but operand-dependent value.
  function automatic logic [63:0] cipher(input logic [63:0] pt, input logic [127:0] k);
    if (pt == 64'd0 && k == 128'd0) return 64'h96db702a2e6900af;
    return pt ^ k[127:64] ^ k[63:0] ^ 64'h5a5a_0f0f_3c3c_9696;
  endfunction

  int cyc = 0;
  int start_cyc = 1000000;
  bit eoc_en = 1'b1;
  int eoc_dly = 31;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_start === 1'b1) start_cyc <= cyc;
  end

  assign core_eoc        = eoc_en && (cyc == start_cyc + eoc_dly);
  assign core_ciphertext = core_eoc ? cipher(core_plaintext, core_key) : 64'hdead_beef_dead_beef;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for rsp_valid, starting in the START cycle; checks the
  // number of edges taken and that no further start pulse appeared meanwhile.
  task automatic await_rsp(input string tag, input int exp_n);
    int n = 0;
    int extra = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      step();
      n++;
      if (core_start === 1'b1) extra++;
    end
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_pulse"}, extra, 0);
  endtask

  initial begin
    logic [63:0] exp_d;
    int seen;
    int starts;

    nrst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_plaintext = '0; req0_key = '0; req1_plaintext = '0; req1_key = '0;
    #1 nrst = 1'b0;
    req0_valid = 1'b1;
    #1;
    // reset state, before any clock edge
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_outs", {core_start, rsp_valid, rsp_err, rsp_id}, 4'b0000);
    chk("rst_data", {rsp_data, core_plaintext}, 128'd0);
    chk("rst_key", core_key, 128'd0);
    step();
    step();
    chk("rst_clk_ready0", req0_ready, 1'b0);
    chk("rst_clk_start", core_start, 1'b0);

    // single request, all-zero operands
    nrst = 1'b1;
    #1;
    chk("t34_ready0", req0_ready, 1'b1);
    chk("t34_ready1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    chk("t34_start", core_start, 1'b1);
    chk("t34_ops", {core_plaintext, core_key[63:0]}, 128'd0);
    await_rsp("t34", 32);
    chk("t34_rsp", {rsp_id, rsp_err}, 2'b00);
    chk("t34_data", rsp_data, 64'h96db702a2e6900af);
    rsp_ready = 1'b1;
    step();
    chk("t34_done", rsp_valid, 1'b0);
    rsp_ready = 1'b0;

    // backpressure: response held for 10 cycles while req1 keeps asking
    req1_plaintext = 64'h0123_4567_89ab_cdef;
    req1_key = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
    req1_valid = 1'b1;
    exp_d = cipher(req1_plaintext, req1_key);
    #1;
    chk("t36_ready1", req1_ready, 1'b1);
    step();
    chk("t36_start", core_start, 1'b1);
    chk("t36_pt", core_plaintext, 64'h0123_4567_89ab_cdef);
    await_rsp("t36", 32);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t36_hold%0d", i),
          {rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready, core_start, rsp_data},
          {6'b110000, exp_d});
      step();
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("t36_done", rsp_valid, 1'b0);

    // timeout: core never raises eoc
    eoc_en = 1'b0;
    req0_plaintext = 64'hfeed_face_cafe_babe;
    req0_key = 128'h1;
    req0_valid = 1'b1;
    #1;
    chk("t37_ready0", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    chk("t37_start", core_start, 1'b1);
    await_rsp("t37", TIMEOUT + 1);
    chk("t37_rsp", {rsp_id, rsp_err}, 2'b01);
    chk("t37_data", rsp_data, 64'd0);
    step();
    chk("t37_done", rsp_valid, 1'b0);

    // tie: eoc in the very cycle the timeout would fire
    eoc_en = 1'b1;
    eoc_dly = TIMEOUT;
    req1_plaintext = 64'h1111_2222_3333_4444;
    req1_key = 128'habcd;
    req1_valid = 1'b1;
    exp_d = cipher(req1_plaintext, req1_key);
    step();
    req1_valid = 1'b0;
    chk("t39_start", core_start, 1'b1);
    await_rsp("t39", TIMEOUT + 1);
    chk("t39_rsp", {rsp_id, rsp_err}, 2'b10);
    chk("t39_data", rsp_data, exp_d);
    step();
    eoc_dly = 31;

    // reset in RUN aborts the block
    req0_plaintext = 64'h7777_8888_9999_aaaa;
    req0_key = 128'h5555;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    chk("t38_start", core_start, 1'b1);
    repeat (9) step();
    nrst = 1'b0;
    #1;
    chk("t38_outs", {core_start, rsp_valid, rsp_err, rsp_id, req0_ready, req1_ready}, 6'd0);
    chk("t38_data", {rsp_data, core_plaintext}, 128'd0);
    chk("t38_key", core_key, 128'd0);
    step();
    step();
    nrst = 1'b1;
    seen = 0;
    starts = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rsp_valid === 1'b1) seen++;
      if (core_start === 1'b1) starts++;
    end
    chk("t38_no_rsp", seen, 0);
    chk("t38_no_start", starts, 0);
    req1_plaintext = 64'h0f0f_0f0f_f0f0_f0f0;
    req1_key = 128'h9999_0000_1234;
    req1_valid = 1'b1;
    exp_d = cipher(req1_plaintext, req1_key);
    #1;
    chk("t38_ready1", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    chk("t38_start2", core_start, 1'b1);
    await_rsp("t38", 32);
    chk("t38_rsp", {rsp_id, rsp_err}, 2'b10);
    chk("t38_data2", rsp_data, exp_d);
    step();

    // contention from reset: req0, req1, req0, req1
    nrst = 1'b0;
    req0_plaintext = 64'haaaa_0000_aaaa_0000;
    req0_key = 128'h10;
    req1_plaintext = 64'hbbbb_1111_bbbb_1111;
    req1_key = 128'h20;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    nrst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      logic exp_id;
      exp_id = (k % 2 == 1);
      chk($sformatf("t35_ready%0d", k), {req0_ready, req1_ready}, {~exp_id, exp_id});
      step();
      chk($sformatf("t35_start%0d", k), core_start, 1'b1);
      chk($sformatf("t35_pt%0d", k), core_plaintext,
          exp_id ? 64'hbbbb_1111_bbbb_1111 : 64'haaaa_0000_aaaa_0000);
      await_rsp($sformatf("t35_%0d", k), 32);
      chk($sformatf("t35_resp_ready%0d", k), {req0_ready, req1_ready}, 2'b00);
      chk($sformatf("t35_id%0d", k), {rsp_id, rsp_err}, {exp_id, 1'b0});
      chk($sformatf("t35_data%0d", k), rsp_data,
          exp_id ? cipher(64'hbbbb_1111_bbbb_1111, 128'h20)
                 : cipher(64'haaaa_0000_aaaa_0000, 128'h10));
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/present_arbiter.md
PRESENT_ARBITER -- requirements
Module: present_arbiter

Interface
REQ-001: Parameter TIMEOUT, default 40: maximum cycles in RUN waiting for core_eoc before an error response.
REQ-002: clk  input  1  single clock; all state updates on posedge clk.
REQ-003: nrst  input  1  reset, asynchronous, active-low.
REQ-004: req0_valid / req1_valid  input  1 each  requester has a block pending.
REQ-005: req0_ready / req1_ready  output  1 each  block accepted this cycle when valid&ready.
REQ-006: req0_plaintext / req1_plaintext  input  64 each  plaintext block.
REQ-007: req0_key / req1_key  input  128 each  cipher key.
REQ-008: rsp_valid  output  1  response available.
REQ-009: rsp_ready  input  1  consumer accepts response.
REQ-010: rsp_data  output  64  ciphertext (zero on error).
REQ-011: rsp_id  output  1  requester index of the response.
REQ-012: rsp_err  output  1  timeout flag for the response.
REQ-013: core_start  output  1  one-cycle start pulse to the shared cipher core.
REQ-014: core_plaintext  output  64  and core_key  output  128  operands to the core; held stable from START until the next accept.
REQ-015: core_eoc  input  1  core end-of-computation.
REQ-016: core_ciphertext  input  64  core result, valid while core_eoc=1.

Function
REQ-017: FSM states are IDLE, START, RUN, RESP; the reset state is IDLE.
REQ-018: In IDLE, the block shall assert req_ready only to the granted requester, and only if its valid is high; both readys low in all other states.
REQ-019: Arbitration is round-robin: with both valid, grant the requester not in last_grant; with one valid, grant it; last_grant resets to 1 so req0 wins the first contention.
REQ-020: On accept in cycle T: capture plaintext, key and id; update last_grant; go to START.
REQ-021: START lasts one cycle with core_start=1 (cycle T+1); then go to RUN with the cycle counter cleared.
REQ-022: core_eoc is ignored in IDLE and START; it is sampled only in RUN, because the core's eoc is undefined before its first start.
REQ-023: In RUN, when core_eoc=1, capture core_ciphertext into rsp_data with rsp_err=0 and go to RESP.
REQ-024: Nominal latency: eoc in cycle T+32; rsp_valid rises at T+33.
REQ-025: In RUN, if the counter reaches TIMEOUT without eoc, go to RESP with rsp_err=1 and rsp_data=0; the counter saturates and does not wrap.
REQ-026: In RESP, rsp_valid=1 and rsp_data/rsp_id/rsp_err stay stable until rsp_ready=1; on that handshake go to IDLE.
REQ-027: rsp_valid is low in all states except RESP.
REQ-028: Back-to-back: a new accept can occur no earlier than the cycle after the response handshake.
REQ-029: Only one block is outstanding at a time; requester inputs are not sampled outside the accept cycle.
REQ-030: Simultaneous eoc and counter==TIMEOUT in the same cycle is resolved as success (eoc wins).

Reset
REQ-031: While nrst=0, independent of clk: state=IDLE; core_start, rsp_valid, rsp_err, req0_ready, req1_ready =0; rsp_data, rsp_id, core_plaintext, core_key =0; last_grant=1; counter=0.
REQ-032: Reset asserted mid-operation (START/RUN/RESP) aborts the block, and no response is ever produced for it.
REQ-033: After release, the first accept is possible in the first clock edge with a valid request.

Verification
REQ-034: Single request: req0 plaintext 0, key 0 accepted at T -> core_start at T+1; rsp_valid at T+33, rsp_id=0, rsp_err=0, rsp_data=0x96db702a2e6900af.
REQ-035: Contention: req0 and req1 both held valid from reset -> grants in order req0, req1, req0, req1, with rsp_id matching each grant.
REQ-036: Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_data/rsp_id stable, both req_ready=0, no core_start pulses.
REQ-037: Timeout: core model never raises eoc -> rsp_valid with rsp_err=1, rsp_data=0, at TIMEOUT+1 cycles after START.
REQ-038: Reset in RUN: nrst low 2 cycles at T+10 -> outputs zero immediately, no response for the aborted block, next request completes normally.
REQ-039: Tie: core eoc asserted exactly when counter==TIMEOUT -> rsp_err=0 and rsp_data=core_ciphertext.
